deque_sequencer: RTL and testbench
==================================

// Module: deque_sequencer
// PURPOSE
//  Host-side master for the dual 16-word deque interface: drives push/pop/select/data_in
//  and consumes data_out plus the four full/empty flags.
//  Accepts byte commands on a valid/ready channel and issues single-cycle deque strobes.
//  Refuses illegal operations (push to full, pop from empty) and returns one response per
//  command on a valid/ready channel.
//  Sits between the chip I/O command decoder and the dual deque.
// PARAMETERS
//  POP_LATENCY  1  cycles from the dq_pop strobe cycle to the dq_data_out sample edge (0..3)
//  ERR_W        8  width of the saturating error counter
// PORTS
//  clk          in   1      single clock, rising edge
//  rst          in   1      synchronous, active-high reset
//  cmd_valid    in   1      command present
//  cmd_ready    out  1      sequencer accepts command (high only in IDLE)
//  cmd_op       in   2      00 PUSH, 01 POP, 10 MOVE (pop sel, push ~sel), 11 STATUS
//  cmd_sel      in   1      target deque (source deque for MOVE)
//  cmd_data     in   8      PUSH payload
//  rsp_valid    out  1      response present
//  rsp_ready    in   1      host consumes response
//  rsp_data     out  8      response byte
//  rsp_err      out  1      command refused
//  dq_select    out  1      deque select to the dual deque
//  dq_push      out  1      push strobe, one cycle
//  dq_pop       out  1      pop strobe, one cycle
//  dq_data_in   out  8      push data; 0 when dq_push is low
//  dq_data_out  in   8      pop data from the dual deque
//  s0_empty, s0_full, s1_empty, s1_full  in  1 each  deque status flags
//  err_count    out  ERR_W  refused-command count; saturates at all-ones
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except cmd_ready=1; err_count=0.
//  Reset wins over every other event. A MOVE interrupted after its pop loses that byte.
//  Accept: cmd_valid & cmd_ready at edge E0 latches op/sel/data.
//  Accept: the cycle after E0 is ISSUE.
//  Flags are sampled combinationally in ISSUE.
//  ISSUE, checks (no strobe issued on error):
//   PUSH  error if full[sel]
//   POP   error if empty[sel]
//   MOVE  error if empty[sel] or full[~sel]
//   STATUS never errors
//  ISSUE, strobes:
//   PUSH  dq_push=1, dq_select=sel, dq_data_in=data -> RESP
//   POP/MOVE  dq_pop=1, dq_select=sel -> WAIT
//   STATUS  capture {4'b0,s1_full,s1_empty,s0_full,s0_empty} -> RESP
//  WAIT: counts POP_LATENCY cycles; dq_select held at sel.
//  WAIT: dq_data_out is captured on the edge ending cycle ISSUE+POP_LATENCY.
//  WAIT: with POP_LATENCY=0, capture happens on the ISSUE edge and WAIT is skipped.
//  WAIT exit: POP -> RESP; MOVE -> PUSH2.
//  PUSH2 (one cycle): dq_push=1, dq_select=~sel, dq_data_in=captured byte -> RESP.
//  RESP: rsp_valid=1; rsp_data/rsp_err are stable until rsp_ready; then -> IDLE.
//  rsp_data: PUSH 0x00; POP and MOVE the captured byte; STATUS the flag byte; error 0x00.
//  rsp_err=1: err_count increments on entering RESP; it saturates and never wraps.
//  Strobes: dq_push and dq_pop are never high together.
//  Strobes: never high outside ISSUE/PUSH2, at most one per cycle.
//  dq_select is 0 in IDLE and RESP.
//  One command in flight: cmd_ready=0 from ISSUE through RESP.
//  A command offered while busy is held by the host and is not dropped.
//  Latency, PUSH: rsp_valid high 2 cycles after accept.
//  Latency, POP: 2+POP_LATENCY cycles; MOVE: 3+POP_LATENCY cycles.
//  Flag changes during WAIT/PUSH2 are ignored; the ISSUE check is final.
// TESTING
//  1 reset; PUSH sel0 0xA5 -> one-cycle dq_push, dq_select=0, dq_data_in=0xA5;
//    rsp 0x00 err=0 two cycles after accept.
//  2 s1_empty=1; POP sel1 -> no dq_pop strobe; rsp_err=1, rsp_data=0x00; err_count 0->1.
//  3 POP sel0 with dq_data_out=0x3C at the sample edge (POP_LATENCY=1) -> rsp_data=0x3C.
//  4 MOVE sel0, s1_full=0, dq_data_out=0x77 -> dq_pop sel0, then dq_push sel1 data 0x77,
//    then rsp 0x77.
//  5 rsp_ready held low 5 cycles -> rsp stable, cmd_ready=0, no strobes;
//    next command accepted after the release.
//  6 256 refused pushes (s0_full=1) -> err_count stays 255;
//    rst mid-MOVE in WAIT -> IDLE, strobes 0, no response.

Source files
------------

// File: rtl/deque_sequencer.sv
// rtl/deque_sequencer.sv - command sequencer driving a dual 16-word deque
//
// Purpose: accepts byte commands (PUSH, POP, MOVE, STATUS) on a valid/ready
// channel, checks them against the deque full/empty flags, issues single-cycle
// push/pop strobes, and returns exactly one response per command.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake (ready only when idle)
//   cmd_op, cmd_sel, cmd_data     opcode, target deque, push payload
//   rsp_valid/rsp_ready           response handshake
//   rsp_data, rsp_err             response byte, refused flag
//   dq_select, dq_push, dq_pop    deque select and one-cycle strobes
//   dq_data_in, dq_data_out       push data out, pop data back
//   s0_empty..s1_full             deque status flags
//   err_count                     saturating count of refused commands
module deque_sequencer #(
  parameter int POP_LATENCY = 1,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic             cmd_sel,
  input  logic [7:0]       cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_data,
  output logic             rsp_err,
  output logic             dq_select,
  output logic             dq_push,
  output logic             dq_pop,
  output logic [7:0]       dq_data_in,
  input  logic [7:0]       dq_data_out,
  input  logic             s0_empty,
  input  logic             s0_full,
  input  logic             s1_empty,
  input  logic             s1_full,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [1:0] OP_PUSH   = 2'b00;
  localparam logic [1:0] OP_POP    = 2'b01;
  localparam logic [1:0] OP_MOVE   = 2'b10;
  localparam logic [1:0] LAT       = POP_LATENCY[1:0];

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, PUSH2, RESP} state_t;

  state_t     state;
  logic [1:0] op_q;
  logic       sel_q;
  logic [7:0] data_q;
  logic [7:0] byte_q;   // popped byte, doubles as the response byte
  logic       err_q;
  logic [1:0] wait_cnt;

  logic empty_sel, full_sel, full_other, issue_err;

  assign empty_sel  = sel_q ? s1_empty : s0_empty;
  assign full_sel   = sel_q ? s1_full  : s0_full;
  assign full_other = sel_q ? s0_full  : s1_full;

  always_comb begin
    issue_err = 1'b0;
    case (op_q)
      OP_PUSH: issue_err = full_sel;
      OP_POP:  issue_err = empty_sel;
      OP_MOVE: issue_err = empty_sel | full_other;
      default: issue_err = 1'b0;
    endcase
  end

  // Strobes depend on the live flags during ISSUE, so they are decoded
  // from state rather than registered.
  always_comb begin
    dq_select  = 1'b0;
    dq_push    = 1'b0;
    dq_pop     = 1'b0;
    dq_data_in = 8'h00;
    case (state)
      ISSUE: begin
        dq_select = sel_q;
        if (!issue_err) begin
          if (op_q == OP_PUSH) begin
            dq_push    = 1'b1;
            dq_data_in = data_q;
          end else if (op_q == OP_POP || op_q == OP_MOVE) begin
            dq_pop = 1'b1;
          end
        end
      end
      WAIT:  dq_select = sel_q;
      PUSH2: begin
        dq_push    = 1'b1;
        dq_select  = ~sel_q;
        dq_data_in = byte_q;
      end
      default: ;
    endcase
  end

  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_data  = rsp_valid ? byte_q : 8'h00;
  assign rsp_err   = rsp_valid & err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= 2'b00;
      sel_q     <= 1'b0;
      data_q    <= 8'h00;
      byte_q    <= 8'h00;
      err_q     <= 1'b0;
      wait_cnt  <= 2'd0;
      err_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q   <= cmd_op;
            sel_q  <= cmd_sel;
            data_q <= cmd_data;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= 2'd1;
          err_q    <= issue_err;
          byte_q   <= 8'h00;
          if (issue_err) begin
            if (err_count != '1) err_count <= err_count + ERR_W'(1);
            state <= RESP;
          end else if (op_q == OP_POP || op_q == OP_MOVE) begin
            if (LAT == 2'd0) begin
              byte_q <= dq_data_out;
              state  <= (op_q == OP_POP) ? RESP : PUSH2;
            end else begin
              state <= WAIT;
            end
          end else begin
            if (op_q != OP_PUSH)
              byte_q <= {4'b0000, s1_full, s1_empty, s0_full, s0_empty};
            state <= RESP;
          end
        end
        WAIT: begin
          if (wait_cnt == LAT) begin
            byte_q <= dq_data_out;
            state  <= (op_q == OP_POP) ? RESP : PUSH2;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        PUSH2: state <= RESP;
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_deque_sequencer.sv
// tb/tb_deque_sequencer.sv - randomized self-checking bench for deque_sequencer
//
// Purpose: drives host commands, emulates the dual deque as two stacks, and
// predicts every response from a queue-based model of command semantics.
// Ports: none (top-level bench).
module tb_deque_sequencer;

  localparam int LAT = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_sel;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       rsp_valid, rsp_ready, rsp_err;
  logic [7:0] rsp_data;
  logic       dq_select, dq_push, dq_pop;
  logic [7:0] dq_data_in, dq_data_out;
  logic       s0_empty, s0_full, s1_empty, s1_full;
  logic [7:0] err_count;

  always #5 clk = ~clk;

  deque_sequencer #(.POP_LATENCY(LAT), .ERR_W(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_sel(cmd_sel), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err),
    .dq_select(dq_select), .dq_push(dq_push), .dq_pop(dq_pop),
    .dq_data_in(dq_data_in), .dq_data_out(dq_data_out),
    .s0_empty(s0_empty), .s0_full(s0_full), .s1_empty(s1_empty),
    .s1_full(s1_full), .err_count(err_count)
  );

  // Dual deque emulation: two 16-entry stacks; popped byte appears one cycle
  // after the pop strobe.
  logic [7:0] mem0 [0:15];
  logic [7:0] mem1 [0:15];
  int         cnt0 = 0, cnt1 = 0, env_bad = 0, both_bad = 0;
  logic [7:0] pop_data = 8'h00;
  logic       ovr_e0 = 0, ovr_f0 = 0, ovr_e1 = 0, ovr_f1 = 0;

  assign dq_data_out = pop_data;
  assign s0_empty = (cnt0 == 0)  || ovr_e0;
  assign s0_full  = (cnt0 >= 16) || ovr_f0;
  assign s1_empty = (cnt1 == 0)  || ovr_e1;
  assign s1_full  = (cnt1 >= 16) || ovr_f1;

  always @(posedge clk) begin
    if (dq_push && dq_pop) both_bad <= both_bad + 1;
    if (dq_push) begin
      if (dq_select) begin
        if (cnt1 < 16) begin mem1[4'(cnt1)] <= dq_data_in; cnt1 <= cnt1 + 1; end
        else env_bad <= env_bad + 1;
      end else begin
        if (cnt0 < 16) begin mem0[4'(cnt0)] <= dq_data_in; cnt0 <= cnt0 + 1; end
        else env_bad <= env_bad + 1;
      end
    end else if (dq_pop) begin
      if (dq_select) begin
        if (cnt1 > 0) begin pop_data <= mem1[4'(cnt1 - 1)]; cnt1 <= cnt1 - 1; end
        else env_bad <= env_bad + 1;
      end else begin
        if (cnt0 > 0) begin pop_data <= mem0[4'(cnt0 - 1)]; cnt0 <= cnt0 - 1; end
        else env_bad <= env_bad + 1;
      end
    end
  end

  // Reference model state
  logic [7:0] mq0 [$];
  logic [7:0] mq1 [$];
  int         merr = 0;
  int         n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic sel, input logic [7:0] data,
                        input int hold);
    logic       e0, f0, e1, f1, es, fs, fo, exp_err, push_sel;
    logic [7:0] exp_rsp, push_dat, v;
    int         lat, push_k, pop_k, k;
    bit         got;
    e0 = (mq0.size() == 0)  || ovr_e0;
    f0 = (mq0.size() >= 16) || ovr_f0;
    e1 = (mq1.size() == 0)  || ovr_e1;
    f1 = (mq1.size() >= 16) || ovr_f1;
    es = sel ? e1 : e0;
    fs = sel ? f1 : f0;
    fo = sel ? f0 : f1;
    case (op)
      2'b00:   exp_err = fs;
      2'b01:   exp_err = es;
      2'b10:   exp_err = es | fo;
      default: exp_err = 1'b0;
    endcase
    exp_rsp = 8'h00; push_k = 0; pop_k = 0; lat = 2; push_sel = 1'b0; push_dat = 8'h00;
    if (exp_err) begin
      if (merr < 255) merr++;
    end else begin
      case (op)
        2'b00: begin
          push_k = 1; push_sel = sel; push_dat = data;
          if (sel) mq1.push_back(data); else mq0.push_back(data);
        end
        2'b01: begin
          pop_k = 1; lat = 2 + LAT;
          exp_rsp = sel ? mq1.pop_back() : mq0.pop_back();
        end
        2'b10: begin
          pop_k = 1; lat = 3 + LAT; push_k = 2 + LAT; push_sel = ~sel;
          v = sel ? mq1.pop_back() : mq0.pop_back();
          if (sel) mq0.push_back(v); else mq1.push_back(v);
          push_dat = v; exp_rsp = v;
        end
        default: exp_rsp = {4'b0000, f1, e1, f0, e0};
      endcase
    end

    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_sel = sel; cmd_data = data;
    check("cmd_ready_idle", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_data = 8'($urandom);
    k = 1; got = 0;
    while (!got && k <= 12) begin
      if (rsp_valid) got = 1;
      else begin
        check("push_strobe", dq_push, (k == push_k));
        check("pop_strobe", dq_pop, (k == pop_k));
        check("cmd_ready_busy", cmd_ready, 0);
        if (dq_push) begin
          check("push_sel", dq_select, push_sel);
          check("push_data", dq_data_in, push_dat);
        end else check("data_in_zero", dq_data_in, 0);
        if (dq_pop) check("pop_sel", dq_select, sel);
        @(negedge clk);
        k++;
      end
    end
    if (!got) begin
      check("rsp_timeout", 0, 1);
      return;
    end
    check("latency", k, lat);
    for (int h = 0; h <= hold; h++) begin
      check("rsp_valid", rsp_valid, 1);
      check("rsp_data", rsp_data, exp_rsp);
      check("rsp_err", rsp_err, exp_err);
      check("err_count", err_count, merr);
      check("resp_quiet", {cmd_ready, dq_push, dq_pop, dq_select}, 0);
      if (h < hold) @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_released", rsp_valid, 0);
    check("cmd_ready_back", cmd_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_sel = 1'b0;
    cmd_data = 8'h00; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outputs",
          {cmd_ready, rsp_valid, rsp_err, dq_push, dq_pop, dq_select}, 6'b100000);
    check("rst_bytes", {rsp_data, dq_data_in, err_count}, 0);
    rst = 1'b0;

    do_cmd(2'b00, 1'b0, 8'hA5, 0);   // PUSH sel0
    do_cmd(2'b01, 1'b1, 8'h00, 0);   // POP from empty sel1
    do_cmd(2'b00, 1'b0, 8'h3C, 0);
    do_cmd(2'b01, 1'b0, 8'h00, 0);   // returns 0x3C
    do_cmd(2'b00, 1'b0, 8'h77, 0);
    do_cmd(2'b10, 1'b0, 8'h00, 0);   // MOVE 0x77 to sel1
    do_cmd(2'b11, 1'b0, 8'h00, 5);   // STATUS, host stalls response
    do_cmd(2'b11, 1'b1, 8'h00, 0);

    ovr_f0 = 1'b1;
    for (int i = 0; i < 256; i++) do_cmd(2'b00, 1'b0, 8'($urandom), 0);
    ovr_f0 = 1'b0;
    check("err_saturated", err_count, 255);

    // Reset during the WAIT of a MOVE: popped byte is lost, nothing answers.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_sel = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    void'(mq0.pop_back());
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    merr = 0;
    for (int i = 0; i < 4; i++) begin
      check("rst_mid_move",
            {cmd_ready, rsp_valid, dq_push, dq_pop, dq_select}, 5'b10000);
      check("rst_err_count", err_count, 0);
      @(negedge clk);
    end

    for (int i = 0; i < 200; i++) begin
      ovr_e0 = ($urandom_range(0, 9) == 0);
      ovr_f0 = ($urandom_range(0, 9) == 0);
      ovr_e1 = ($urandom_range(0, 9) == 0);
      ovr_f1 = ($urandom_range(0, 9) == 0);
      do_cmd(2'($urandom), 1'($urandom), 8'($urandom), $urandom_range(0, 3));
    end
    ovr_e0 = 0; ovr_f0 = 0; ovr_e1 = 0; ovr_f1 = 0;

    @(negedge clk);
    check("env_cnt0", cnt0, mq0.size());
    check("env_cnt1", cnt1, mq1.size());
    for (int i = 0; i < mq0.size() && i < 16; i++) check("mem0", mem0[4'(i)], mq0[i]);
    for (int i = 0; i < mq1.size() && i < 16; i++) check("mem1", mem1[4'(i)], mq1[i]);
    check("env_violation", env_bad, 0);
    check("push_pop_overlap", both_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
